// File: rtl/counter_pkg.sv
// counter_pkg: shared constants and helpers
// for the cascaded counter chain.
package counter_pkg;

    localparam logic CNT_DOWN = 1'b0;
    localparam logic CNT_UP   = 1'b1;

    function automatic logic [31:0] clamp_digit(
        input logic [31:0] value,
        input logic [31:0] max
    );
        return (value > max) ? max : value;
    endfunction

endpackage

// File: rtl/counter_chain_digit.sv
// counter_digit: one modulo DIGIT_MAX+1 digit
// with up/down step, clear and clamped load.
module counter_digit
    import counter_pkg::*;
#(
    parameter  int DIGIT_MAX = 9,
    localparam int DW = $clog2(DIGIT_MAX + 1)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          step_in,
    input  logic          up,
    input  logic          clear,
    input  logic          load,
    input  logic [DW-1:0] load_digit,
    output logic [DW-1:0] digit,
    output logic          term_out
);

    localparam logic [DW-1:0] MAXV = DW'(DIGIT_MAX);

    logic [DW-1:0] nxt;
    logic [DW-1:0] ld_val;

    assign ld_val = DW'(clamp_digit(32'(load_digit),
                                    32'(DIGIT_MAX)));

    // Codes above MAXV count as terminal going up so
    // a corrupted digit wraps to 0 and carries.
    always_comb begin
        nxt = digit;
        if (up == CNT_UP)
            nxt = (digit >= MAXV) ? '0 : digit + DW'(1);
        else
            nxt = (digit == '0) ? MAXV : digit - DW'(1);
    end

    assign term_out = (up == CNT_UP) ? (digit >= MAXV)
                                     : (digit == '0);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            digit <= '0;
        else if (clear)
            digit <= '0;
        else if (load)
            digit <= ld_val;
        else if (step_in)
            digit <= nxt;
    end

endmodule

// File: rtl/counter_chain.sv
// counter_chain: NUM_DIGITS cascaded digits with
// ripple carry/borrow and registered wrap flags.
module counter_chain
    import counter_pkg::*;
#(
    parameter  int NUM_DIGITS = 4,
    parameter  int DIGIT_MAX  = 9,
    localparam int DW = $clog2(DIGIT_MAX + 1)
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   enabled,
    input  logic                   up,
    input  logic                   clear,
    input  logic                   load,
    input  logic [NUM_DIGITS*DW-1:0] load_value,
    output logic [NUM_DIGITS*DW-1:0] value,
    output logic                   overflow,
    output logic                   underflow
);

    logic [NUM_DIGITS:0]   carry;
    logic [NUM_DIGITS-1:0] term;

    // carry[i] is the step request reaching digit i;
    // carry[NUM_DIGITS] means the whole chain wraps.
    assign carry[0] = enabled;

    for (genvar g = 0; g < NUM_DIGITS; g++) begin : g_digit
        counter_digit #(
            .DIGIT_MAX (DIGIT_MAX)
        ) u_digit (
            .clk        (clk),
            .rst_n      (rst_n),
            .step_in    (carry[g]),
            .up         (up),
            .clear      (clear),
            .load       (load),
            .load_digit (load_value[g*DW +: DW]),
            .digit      (value[g*DW +: DW]),
            .term_out   (term[g])
        );
        assign carry[g+1] = carry[g] & term[g];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            overflow  <= 1'b0;
            underflow <= 1'b0;
        end else if (clear || load) begin
            overflow  <= 1'b0;
            underflow <= 1'b0;
        end else if (enabled) begin
            overflow  <= (up == CNT_UP)   && carry[NUM_DIGITS];
            underflow <= (up == CNT_DOWN) && carry[NUM_DIGITS];
        end
    end

endmodule

// File: tb/tb_counter_chain.sv
// tb_counter_chain: scoreboard bench, integer
// reference model in base DIGIT_MAX+1.
module tb_counter_chain;

    typedef struct {
        int unsigned n;
        bit          o;
        bit          u;
    } st_t;

    typedef struct {
        int unsigned v;
        bit          o;
        bit          u;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic        a_en = 0, a_up = 0, a_clr = 0, a_ld = 0;
    logic [15:0] a_lv = '0;
    logic [15:0] a_value;
    logic        a_ovf, a_unf;

    logic        b_en = 0, b_up = 0, b_clr = 0, b_ld = 0;
    logic [5:0]  b_lv = '0;
    logic [5:0]  b_value;
    logic        b_ovf, b_unf;

    counter_chain #(.NUM_DIGITS(4), .DIGIT_MAX(9)) dut_a (
        .clk(clk), .rst_n(rst_n), .enabled(a_en), .up(a_up),
        .clear(a_clr), .load(a_ld), .load_value(a_lv),
        .value(a_value), .overflow(a_ovf), .underflow(a_unf)
    );

    counter_chain #(.NUM_DIGITS(2), .DIGIT_MAX(5)) dut_b (
        .clk(clk), .rst_n(rst_n), .enabled(b_en), .up(b_up),
        .clear(b_clr), .load(b_ld), .load_value(b_lv),
        .value(b_value), .overflow(b_ovf), .underflow(b_unf)
    );

    int checks = 0;
    int fails  = 0;
    exp_t qa[$];
    exp_t qb[$];
    st_t sa = '{0, 0, 0};
    st_t sb = '{0, 0, 0};

    task automatic chk(string nm, int unsigned act, int unsigned req);
        checks++;
        if (act != req) begin
            fails++;
            $display("FAIL %s: got %0h required %0h", nm, act, req);
        end
    endtask

    function automatic int unsigned ipow(int b, int nd);
        int unsigned r = 1;
        for (int i = 0; i < nd; i++) r *= b;
        return r;
    endfunction

    function automatic int unsigned pack(int unsigned n, int b,
                                         int nd, int dw);
        int unsigned r = 0;
        for (int i = 0; i < nd; i++) begin
            r |= (n % b) << (i * dw);
            n /= b;
        end
        return r;
    endfunction

    function automatic int unsigned unpack_clamp(int unsigned lv,
                                                 int b, int nd, int dw);
        int unsigned n = 0;
        int unsigned mul = 1;
        int unsigned d;
        for (int i = 0; i < nd; i++) begin
            d = (lv >> (i * dw)) & ((1 << dw) - 1);
            if (d > b - 1) d = b - 1;
            n += d * mul;
            mul *= b;
        end
        return n;
    endfunction

    function automatic st_t mdl(st_t s, int b, int nd, int dw,
                                bit en, bit upd, bit c, bit l,
                                int unsigned lv);
        int unsigned m = ipow(b, nd);
        if (c) begin
            s = '{0, 0, 0};
        end else if (l) begin
            s = '{unpack_clamp(lv, b, nd, dw), 0, 0};
        end else if (en) begin
            if (upd) begin
                s.o = (s.n == m - 1);
                s.u = 0;
                s.n = (s.n + 1) % m;
            end else begin
                s.u = (s.n == 0);
                s.o = 0;
                s.n = (s.n + m - 1) % m;
            end
        end
        return s;
    endfunction

    task automatic cyc_a(bit en, bit u, bit c, bit l, int unsigned lv);
        @(negedge clk);
        a_en = en; a_up = u; a_clr = c; a_ld = l; a_lv = 16'(lv);
        sa = mdl(sa, 10, 4, 4, en, u, c, l, lv);
        qa.push_back('{pack(sa.n, 10, 4, 4), sa.o, sa.u});
        @(posedge clk);
    endtask

    task automatic cyc_b(bit en, bit u, bit c, bit l, int unsigned lv);
        @(negedge clk);
        b_en = en; b_up = u; b_clr = c; b_ld = l; b_lv = 6'(lv);
        sb = mdl(sb, 6, 2, 3, en, u, c, l, lv);
        qb.push_back('{pack(sb.n, 6, 2, 3), sb.o, sb.u});
        @(posedge clk);
    endtask

    always begin : mon
        exp_t e;
        @(posedge clk);
        #1;
        if (qa.size() > 0) begin
            e = qa.pop_front();
            chk("a_value", 32'(a_value), e.v);
            chk("a_overflow", 32'(a_ovf), 32'(e.o));
            chk("a_underflow", 32'(a_unf), 32'(e.u));
        end
        if (qb.size() > 0) begin
            e = qb.pop_front();
            chk("b_value", 32'(b_value), e.v);
            chk("b_overflow", 32'(b_ovf), 32'(e.o));
            chk("b_underflow", 32'(b_unf), 32'(e.u));
        end
    end

    initial begin
        repeat (2) @(posedge clk);
        #1;
        chk("reset_value", 32'(a_value), 0);
        chk("reset_flags", 32'({a_ovf, a_unf}), 0);
        @(negedge clk);
        rst_n = 1'b1;

        // async reset mid-count
        cyc_a(0, 1, 0, 1, 32'h0357);
        @(negedge clk);
        a_ld = 0; a_en = 1; a_up = 1;
        #2 rst_n = 1'b0;
        #1;
        chk("async_rst_value", 32'(a_value), 0);
        chk("async_rst_flags", 32'({a_ovf, a_unf}), 0);
        sa = '{0, 0, 0};
        sb = '{0, 0, 0};
        @(negedge clk);
        a_en = 0;
        rst_n = 1'b1;
        cyc_a(1, 1, 0, 0, 0);
        #2 chk("first_step", 32'(a_value), 32'h0001);

        // ripple carry across three digits
        cyc_a(0, 1, 0, 1, 32'h0998);
        cyc_a(1, 1, 0, 0, 0);
        #2 chk("carry_0999", 32'(a_value), 32'h0999);
        cyc_a(1, 1, 0, 0, 0);
        #2 chk("carry_1000", 32'(a_value), 32'h1000);
        cyc_a(1, 1, 0, 0, 0);
        #2 chk("carry_1001", 32'(a_value), 32'h1001);
        chk("carry_no_ovf", 32'(a_ovf), 0);

        // overflow and stickiness
        cyc_a(0, 1, 0, 1, 32'h9999);
        cyc_a(1, 1, 0, 0, 0);
        #2 chk("wrap_value", 32'(a_value), 0);
        chk("wrap_ovf", 32'(a_ovf), 1);
        for (int i = 0; i < 5; i++) cyc_a(0, 0, 0, 0, 0);
        #2 chk("sticky_ovf", 32'(a_ovf), 1);
        cyc_a(1, 1, 0, 0, 0);
        #2 chk("ovf_cleared", 32'(a_ovf), 0);

        // underflow and borrow
        cyc_a(0, 1, 0, 1, 32'h0000);
        cyc_a(1, 0, 0, 0, 0);
        #2 chk("borrow_9999", 32'(a_value), 32'h9999);
        chk("unf_set", 32'(a_unf), 1);
        cyc_a(1, 0, 0, 0, 0);
        #2 chk("borrow_9998", 32'(a_value), 32'h9998);
        chk("unf_cleared", 32'(a_unf), 0);
        cyc_a(0, 0, 0, 1, 32'h1000);
        cyc_a(1, 0, 0, 0, 0);
        #2 chk("borrow_0999", 32'(a_value), 32'h0999);

        // priority and clamping
        cyc_a(0, 0, 0, 1, 32'h0042);
        cyc_a(1, 1, 1, 1, 32'h1234);
        #2 chk("clear_prio", 32'(a_value), 0);
        cyc_a(1, 1, 0, 1, 32'h00F5);
        #2 chk("load_clamp", 32'(a_value), 32'h0095);

        // small chain: full cycle of 36 steps
        for (int i = 0; i < 36; i++) begin
            cyc_b(1, 1, 0, 0, 0);
            #2 chk("b_ovf_step", 32'(b_ovf), (i == 35) ? 1 : 0);
        end
        chk("b_full_cycle", 32'(b_value), 0);
        cyc_b(0, 1, 0, 1, 32'b001_000);
        cyc_b(1, 0, 0, 0, 0);
        #2 chk("b_dir_toggle", 32'(b_value), 32'b000_101);

        // randomized traffic on both chains
        for (int i = 0; i < 400; i++) begin
            fork
                cyc_a($urandom_range(0, 3) != 0, 1'($urandom),
                      $urandom_range(0, 31) == 0,
                      $urandom_range(0, 15) == 0, $urandom);
                cyc_b($urandom_range(0, 3) != 0, 1'($urandom),
                      $urandom_range(0, 31) == 0,
                      $urandom_range(0, 15) == 0, $urandom);
            join
        end

        repeat (3) @(posedge clk);
        #2;
        chk("qa_drained", qa.size(), 0);
        chk("qb_drained", qb.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures",
                 checks, fails);
        $finish;
    end

endmodule
